// File: rtl/voice_ram_preload.sv
// ROM-preloaded voice/patch RAM: copies the instrument ROM into RAM after reset
// or reload, then serves a byte-enabled rw port and a read-only port.
module voice_ram_preload #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 38,
  parameter int ADDR_W  = 6,
  parameter int ROM_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0]   rwaddr,
  input  logic [DATA_W-1:0]   idata,
  input  logic [ADDR_W-1:0]   roaddr,
  output logic [DATA_W-1:0]   odata,
  output logic [DATA_W-1:0]   rodata,
  input  logic                reload,
  output logic                ready,
  output logic                wr_drop,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data
);
  localparam int NB = DATA_W / 8;
  localparam int WCNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ISSUE, WAIT, STORE, RUN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                ready_q, wr_drop_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [DATA_W-1:0]   odata_q, rodata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_run, rw_ok, ro_ok, wr_ok, ready_d, last_store;
  logic [DATA_W-1:0]   rw_word, ro_word, merged, odata_d, rodata_d;

  assign in_run     = (state_q == RUN);
  assign rw_ok      = (rwaddr <= LAST);
  assign ro_ok      = (roaddr <= LAST);
  assign wr_ok      = wr && in_run && !reload && rw_ok && !reset;
  assign last_store = (state_q == STORE) && (idx_q == LAST);
  // Next-cycle ready; outputs are gated on it so they are zero whenever ready is low.
  assign ready_d    = last_store || (in_run && !reload);

  always_comb begin
    rw_word = '0;
    ro_word = '0;
    // The final STORE edge also loads the outputs, so forward the entry being stored.
    if (rw_ok) rw_word = (last_store && rwaddr == idx_q) ? rom_data : mem[rwaddr];
    if (ro_ok) ro_word = (last_store && roaddr == idx_q) ? rom_data : mem[roaddr];
    merged = rw_word;
    for (int b = 0; b < NB; b++)
      if (wbe[b]) merged[8*b +: 8] = idata[8*b +: 8];
    odata_d  = '0;
    rodata_d = '0;
    if (ready_d) begin
      odata_d  = wr_ok ? merged : rw_word;
      rodata_d = (wr_ok && roaddr == rwaddr) ? merged : ro_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ISSUE;
      idx_q      <= '0;
      wcnt_q     <= '0;
      ready_q    <= 1'b0;
      odata_q    <= '0;
      rodata_q   <= '0;
      wr_drop_q  <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      wr_drop_q <= wr && (!in_run || reload || !rw_ok);
      odata_q   <= odata_d;
      rodata_q  <= rodata_d;
      case (state_q)
        ISSUE: begin
          rom_addr_q <= idx_q;
          wcnt_q     <= WCNT_W'(ROM_LAT - 1);
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wcnt_q == '0) state_q <= STORE;
          else              wcnt_q  <= wcnt_q - 1'b1;
        end
        STORE: begin
          if (idx_q == LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ISSUE;
          end
        end
        RUN: begin
          if (reload) begin
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ISSUE;
          end
        end
        default: state_q <= ISSUE;
      endcase
    end
  end

  // RAM array kept out of reset; init rewrites every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == STORE) mem[idx_q]  <= rom_data;
      else if (wr_ok)       mem[rwaddr] <= merged;
    end
  end

  assign odata    = odata_q;
  assign rodata   = rodata_q;
  assign ready    = ready_q;
  assign wr_drop  = wr_drop_q;
  assign rom_addr = rom_addr_q;
endmodule
